// File: rtl/rt_pkg.sv
// Shared Q16.16 ray/triangle types and constants for the ray-triangle dispatch path.
package rt_pkg;

    typedef logic signed [0:2][31:0] vec3_t;
    typedef vec3_t [0:2] tri_t;
    typedef vec3_t [0:1] ray_t;

    localparam logic [31:0] FIX_ONE = 32'h0001_0000;
    localparam logic [31:0] T_NONE  = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic t_less(input logic [31:0] a, input logic [31:0] b);
        return $signed(a) < $signed(b);
    endfunction

endpackage

// File: rtl/closest_hit_reg.sv
// Running closest-hit tracker: keeps the smallest signed t seen so far and its index.
module closest_hit_reg
    import rt_pkg::*;
#(
    parameter int          IDX_W  = 16,
    parameter logic [31:0] T_NONE = rt_pkg::T_NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic             hit,
    input  logic [31:0]      t,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      best_t,
    output logic [IDX_W-1:0] best_idx,
    output logic             best_hit
);

    logic better;

    // Strict compare: an equal t later in the stream never displaces the earlier index.
    assign better = valid && hit && t_less(t, best_t);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_t   <= T_NONE;
            best_idx <= '0;
            best_hit <= 1'b0;
        end else if (better) begin
            best_t   <= t;
            best_idx <= idx;
            best_hit <= 1'b1;
        end
    end

endmodule

// File: rtl/tri_dispatch.sv
// Streams triangles 0..N-1 for one ray into the intersection unit and reports the closest hit.
module tri_dispatch
    import rt_pkg::*;
#(
    parameter int          IDX_W        = 16,
    parameter int          MAX_INFLIGHT = 4,
    parameter logic [31:0] T_NONE       = rt_pkg::T_NONE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  ray_t             i_ray,
    input  logic [IDX_W-1:0] i_num_tri,
    output logic             o_busy,
    output logic             o_tri_rd,
    output logic [IDX_W-1:0] o_tri_addr,
    input  tri_t             i_tri_data,
    output logic             o_int_en,
    output tri_t             o_int_tri,
    output ray_t             o_int_ray,
    input  logic [31:0]      i_int_t,
    input  logic             i_int_result,
    input  logic             i_int_valid,
    output logic             o_done,
    output logic             o_hit,
    output logic [31:0]      o_t,
    output logic [IDX_W-1:0] o_tri_idx
);

    localparam int IF_W   = $clog2(MAX_INFLIGHT + 1);
    localparam int STAGES = 1;

    state_t           state, state_nxt;
    ray_t             ray_q;
    logic [IDX_W-1:0] num_tri, rd_cnt, rsp_cnt;
    logic [IF_W-1:0]  inflight;
    logic [STAGES:0]  vld_pipe;
    logic             start_ok, rd, res_ok;
    logic [31:0]      best_t;
    logic [IDX_W-1:0] best_idx;
    logic             best_hit;

    assign start_ok = (state == ST_IDLE) && i_start;
    assign rd       = (state == ST_RUN) && (rd_cnt < num_tri) && (inflight < IF_W'(MAX_INFLIGHT));
    // A strobe with nothing outstanding has no triangle to belong to.
    assign res_ok   = (state == ST_RUN) && i_int_valid && (inflight != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (i_start) state_nxt = ST_RUN;
            ST_RUN:  if (rsp_cnt == num_tri) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ray_q    <= '0;
            num_tri  <= '0;
            rd_cnt   <= '0;
            rsp_cnt  <= '0;
            inflight <= '0;
        end else if (start_ok) begin
            ray_q    <= i_ray;
            num_tri  <= i_num_tri;
            rd_cnt   <= '0;
            rsp_cnt  <= '0;
            inflight <= '0;
        end else begin
            if (rd)     rd_cnt  <= rd_cnt + IDX_W'(1);
            if (res_ok) rsp_cnt <= rsp_cnt + IDX_W'(1);
            unique case ({rd, res_ok})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // vld_pipe[0]: read data present this cycle; vld_pipe[1]: registered triangle on o_int_tri.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe  <= '0;
            o_int_tri <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd};
            if (vld_pipe[0]) o_int_tri <= i_tri_data;
        end
    end

    closest_hit_reg #(
        .IDX_W  (IDX_W),
        .T_NONE (T_NONE)
    ) u_best (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (start_ok),
        .valid    (res_ok),
        .hit      (i_int_result),
        .t        (i_int_t),
        .idx      (rsp_cnt),
        .best_t   (best_t),
        .best_idx (best_idx),
        .best_hit (best_hit)
    );

    // Published result is loaded on entry to DONE so it is valid alongside o_done.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            o_hit     <= 1'b0;
            o_t       <= T_NONE;
            o_tri_idx <= '0;
        end else if (state == ST_RUN && state_nxt == ST_DONE) begin
            o_hit     <= best_hit;
            o_t       <= best_t;
            o_tri_idx <= best_idx;
        end
    end

    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE);
    assign o_tri_rd   = rd;
    assign o_tri_addr = rd_cnt;
    assign o_int_en   = vld_pipe[STAGES];
    assign o_int_ray  = ray_q;

endmodule
